rv32_m_ext: RTL and testbench

RV32_M_EXT -- requirements
Module: rv32_m_ext

---
 rtl/arvi_m_pkg.sv | 30 +++
 rtl/rv32_m_ext.sv | 135 +++++++++++++
 tb/tb_rv32_m_ext.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/arvi_m_pkg.sv
`default_nettype none
// arvi_m_pkg: shared types and constants for the RV32 M-extension iterative unit.
// Rev 1.0
package arvi_m_pkg;

  localparam int unsigned ITER_CNT = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } m_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } m_state_e;

  function automatic logic is_div_op(input m_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv32_m_ext.sv
`default_nettype none
// rv32_m_ext: fixed-latency iterative multiply/divide unit (shift-add / restoring divide).
// Rev 1.0
module rv32_m_ext
  import arvi_m_pkg::*;
#(
  parameter int XLEN = ITER_CNT
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [2:0]      i_f3,
  output logic [XLEN-1:0] o_res,
  output logic            o_ack
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN);

  m_state_e          state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  m_op_e             f3_q, f3_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   res_q, res_d;

  m_op_e             w_op;
  logic              w_s1, w_s2, w_n1, w_n2, w_neg;
  logic [XLEN-1:0]   w_abs1, w_abs2;
  logic [XLEN:0]     w_sum, w_shift, w_trial;
  logic [2*XLEN-1:0] w_mul_acc, w_div_acc, w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_res;

  // Operand sign handling: only the signed variants see a negative operand.
  always_comb begin
    w_op = m_op_e'(i_f3);
    w_s1 = (w_op == OP_MULH) || (w_op == OP_MULHSU) || (w_op == OP_DIV) || (w_op == OP_REM);
    w_s2 = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);
    w_n1 = w_s1 & i_rs1[XLEN-1];
    w_n2 = w_s2 & i_rs2[XLEN-1];
    w_abs1 = w_n1 ? -i_rs1 : i_rs1;
    w_abs2 = w_n2 ? -i_rs2 : i_rs2;
    case (w_op)
      OP_MULH:   w_neg = w_n1 ^ w_n2;
      OP_MULHSU: w_neg = w_n1;
      // A zero divisor yields an all-ones quotient regardless of dividend sign.
      OP_DIV:    w_neg = (w_n1 ^ w_n2) & (|i_rs2);
      OP_REM:    w_neg = w_n1;
      default:   w_neg = 1'b0;
    endcase
  end

  always_comb begin
    w_sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    w_mul_acc = {w_sum, acc_q[XLEN-1:1]};
    // Partial remainder is kept in the upper half, quotient bits shift into the lower half.
    w_shift   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    w_trial   = w_shift - {1'b0, opnd_q};
    w_div_acc = {(w_trial[XLEN] ? w_shift[XLEN-1:0] : w_trial[XLEN-1:0]),
                 acc_q[XLEN-2:0], ~w_trial[XLEN]};
  end

  always_comb begin
    w_prod = neg_q ? -acc_q : acc_q;
    w_quo  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    w_rem  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (f3_q)
      OP_MUL:                      w_res = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_res = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             w_res = w_quo;
      default:                     w_res = w_rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    f3_d    = f3_q;
    neg_d   = neg_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (i_en) begin
          state_d = ST_CALC;
          cnt_d   = '0;
          f3_d    = w_op;
          neg_d   = w_neg;
          opnd_d  = w_abs2;
          acc_d   = {{XLEN{1'b0}}, w_abs1};
        end
      end
      ST_CALC: begin
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          res_d   = w_res;
        end else begin
          acc_d = is_div_op(f3_q) ? w_div_acc : w_mul_acc;
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      f3_q    <= OP_MUL;
      neg_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      f3_q    <= f3_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
    end
  end

  assign o_res = res_q;
  assign o_ack = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_rv32_m_ext.sv
`default_nettype none
// tb_rv32_m_ext: randomized and directed checks of rv32_m_ext against an arithmetic reference.
// Rev 1.0
module tb_rv32_m_ext;

  localparam int XLEN = 32;
  localparam int LIM  = XLEN + 8;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b0;
  logic            i_en  = 1'b0;
  logic [XLEN-1:0] i_rs1 = '0;
  logic [XLEN-1:0] i_rs2 = '0;
  logic [2:0]      i_f3  = '0;
  logic [XLEN-1:0] o_res;
  logic            o_ack;

  int n_cmp = 0;
  int n_err = 0;

  rv32_m_ext #(.XLEN(XLEN)) u_dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (i_en),
    .i_rs1 (i_rs1),
    .i_rs2 (i_rs2),
    .i_f3  (i_f3),
    .o_res (o_res),
    .o_ack (o_ack)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, pu;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        pu = ua / ub; return pu[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        pu = ua % ub; return pu[31:0];
      end
    endcase
  endfunction

  // Issue one request; optionally inject an extra i_en pulse j cycles into the operation.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input int pulse_j);
    logic [31:0] exp;
    int j;
    exp = ref_m(f3, a, b);
    @(posedge i_clk); #1;
    i_f3 = f3; i_rs1 = a; i_rs2 = b; i_en = 1'b1;
    @(posedge i_clk); #1;
    i_en = 1'b0; i_rs1 = $urandom; i_rs2 = $urandom; i_f3 = 3'($urandom);
    @(negedge i_clk);
    j = 0;
    while (!o_ack && j < LIM) begin
      i_en = (j == pulse_j);
      @(negedge i_clk);
      j++;
    end
    i_en = 1'b0;
    chk({tag, "_lat"}, 32'(j), 32'(XLEN + 1));
    chk(tag, o_res, exp);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int acks;
    #12;
    chk("rst_ack", {31'd0, o_ack}, 32'd0);
    chk("rst_res", o_res, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7x-3", -1);
    chk("mul_7x-3_abs", o_res, 32'hFFFF_FFEB);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh", -1);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu", -1);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, "mulhsu", -1);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_-7_2", -1);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_-7_2", -1);
    run_op(3'd5, 32'd100, 32'd7, "divu_100_7", -1);
    run_op(3'd7, 32'd100, 32'd7, "remu_100_7", -1);
    run_op(3'd4, 32'd5, 32'd0, "div_by0", -1);
    run_op(3'd6, 32'd5, 32'd0, "rem_by0", -1);
    run_op(3'd4, 32'hFFFF_FFFB, 32'd0, "div_neg_by0", -1);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", -1);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", -1);

    // Extra pulse mid-operation must not start a second operation.
    run_op(3'd5, 32'd1000, 32'd3, "divu_midpulse", 5);
    acks = 0;
    for (int k = 0; k < XLEN + 6; k++) begin
      @(negedge i_clk);
      if (o_ack) acks++;
    end
    chk("midpulse_extra_acks", 32'(acks), 32'd0);

    // Back-to-back: the second request is raised the cycle after the ack.
    run_op(3'd0, 32'd123, 32'd456, "b2b_first", -1);
    run_op(3'd7, 32'd1000, 32'd7, "b2b_second", -1);

    for (int n = 0; n < 60; n++) begin
      logic [2:0] f3;
      f3 = 3'($urandom_range(0, 7));
      run_op(f3, rnd_opnd(), rnd_opnd(), $sformatf("rnd%0d_f%0d", n, f3), -1);
    end

    // Abort mid-calculation with reset, then resume normally.
    run_op(3'd5, 32'd100, 32'd7, "pre_rst", -1);
    @(posedge i_clk); #1;
    i_f3 = 3'd0; i_rs1 = 32'd9; i_rs2 = 32'd9; i_en = 1'b1;
    @(posedge i_clk); #1;
    i_en = 1'b0;
    for (int k = 0; k < 10; k++) @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    chk("abort_ack", {31'd0, o_ack}, 32'd0);
    chk("abort_res", o_res, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b1;
    acks = 0;
    for (int k = 0; k < XLEN + 4; k++) begin
      @(negedge i_clk);
      if (o_ack) acks++;
    end
    chk("abort_no_ack", 32'(acks), 32'd0);
    run_op(3'd0, 32'd3, 32'd4, "post_rst_mul", -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
